// File: rtl/alu_issue_queue.sv
// alu_issue_queue
//   Operand issue stage in front of a 4-bit combinational ALU. Requests are
//   buffered in a DEPTH-entry FIFO. The head entry is driven onto the ALU
//   inputs, and the ALU result is captured into a registered output slot with
//   a valid/ready handshake. Each result is tagged with its opcode and an
//   8-bit sequence number.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   request valid
//   in_ready   FIFO can accept a request (low while rst is high)
//   in_a/in_b  request operands (4 bit)
//   in_s       request opcode (3 bit)
//   alu_a/b/s  head entry driven to the ALU, or zero when the FIFO is empty
//   alu_y      ALU result (8 bit)
//   out_valid  output slot holds a result
//   out_ready  consumer accepts the result
//   out_y      captured ALU result
//   out_s      opcode of the captured result
//   out_seq    sequence number of the captured result
//   count      FIFO occupancy, not counting the output slot
//
// Stage states (derived from occupancy, no separate state register)
//   state    | meaning
//   EMPTY    | count == 0 and out_valid == 0
//   DRAINING | out_valid == 1, result waiting for the consumer
//   FULL     | count == DEPTH, in_ready == 0

module alu_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_a,
  input  logic [3:0]               in_b,
  input  logic [2:0]               in_s,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic [2:0]               alu_s,
  input  logic [7:0]               alu_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_y,
  output logic [2:0]               out_s,
  output logic [7:0]               out_seq,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // FIFO storage; contents need no reset because occupancy gates every read.
  logic [3:0] mem_a [DEPTH];
  logic [3:0] mem_b [DEPTH];
  logic [2:0] mem_s [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    seq_cnt;

  logic empty;
  logic push;
  logic pop;
  logic free;

  assign empty = (count == '0);

  // Full is decided from count, so a pop in the same cycle never frees a
  // write slot early (no write-through when full).
  assign in_ready = (count < FULL_CNT) && !rst;
  assign push     = in_valid && in_ready;

  // Output slot can take a new result when empty or being drained this cycle.
  assign free = !out_valid || out_ready;
  assign pop  = free && !empty;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    alu_s = '0;
    if (!empty) begin
      alu_a = mem_a[rd_ptr];
      alu_b = mem_b[rd_ptr];
      alu_s = mem_s[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
      mem_s[wr_ptr] <= in_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Result slot. alu_y is sampled in the same cycle the head is presented,
  // so the ALU path has exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_s     <= '0;
      out_seq   <= '0;
      seq_cnt   <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_y     <= alu_y;
      out_s     <= alu_s;
      out_seq   <= seq_cnt;
      seq_cnt   <= seq_cnt + 8'd1;
    end else if (free && out_ready) begin
      // Consumer took the last result and nothing is queued; payload holds.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [2:0] in_s;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_s;
  logic [7:0] alu_y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic [2:0] out_s;
  logic [7:0] out_seq;
  logic [2:0] count;

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_s(in_s),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_s(out_s), .out_seq(out_seq),
    .count(count)
  );

  // ALU stand-in
  assign alu_y = {alu_a, alu_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: request queue plus one result slot.
  typedef struct { logic [3:0] a; logic [3:0] b; logic [2:0] s; } req_t;
  req_t       m_q[$];
  logic       m_ov;
  logic [7:0] m_y;
  logic [2:0] m_s;
  logic [7:0] m_seq;
  int         m_next_seq;
  bit         m_known = 0;
  logic       pre_in_ready;

  task automatic cycle(input logic iv, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] s, input logic ordy, input logic r);
    bit   do_push;
    bit   do_pop;
    req_t h;
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    in_s      = s;
    out_ready = ordy;
    rst       = r;
    #1;
    pre_in_ready = in_ready;
    chk("in_ready", in_ready, (!r && m_q.size() < DEPTH));
    if (m_known) begin
      chk("alu_a", alu_a, m_q.size() != 0 ? m_q[0].a : 4'h0);
      chk("alu_b", alu_b, m_q.size() != 0 ? m_q[0].b : 4'h0);
      chk("alu_s", alu_s, m_q.size() != 0 ? m_q[0].s : 3'h0);
    end
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_ov = 0; m_y = 0; m_s = 0; m_seq = 0; m_next_seq = 0;
      m_known = 1;
    end else if (m_known) begin
      do_push = iv && (m_q.size() < DEPTH);
      do_pop  = (!m_ov || ordy) && (m_q.size() != 0);
      if (do_pop) begin
        h = m_q.pop_front();
        m_ov  = 1;
        m_y   = {h.a, h.b};
        m_s   = h.s;
        m_seq = m_next_seq[7:0];
        m_next_seq = (m_next_seq + 1) % 256;
      end else if (ordy) begin
        m_ov = 0;
      end
      if (do_push) m_q.push_back('{a, b, s});
    end
    #1;
    if (m_known) begin
      chk("out_valid", out_valid, m_ov);
      chk("out_y", out_y, m_y);
      chk("out_s", out_s, m_s);
      chk("out_seq", out_seq, m_seq);
      chk("count", count, m_q.size());
    end
  endtask

  typedef struct {
    logic       iv;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] s;
    logic       ordy;
    logic       r;
    logic       rdy;
    logic       ov;
    logic [7:0] y;
    logic [2:0] os;
    logic [7:0] seq;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[11];

  initial begin
    bit saw255;
    // iv a b s ordy rst | in_ready(pre-edge) out_valid out_y out_s out_seq count (post-edge)
    vecs[0]  = '{1'b0, 4'h0, 4'h0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 8'd0, 3'd0};
    vecs[1]  = '{1'b1, 4'h9, 4'h3, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 8'd0, 3'd1};
    vecs[2]  = '{1'b1, 4'hD, 4'hB, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h93, 3'd0, 8'd0, 3'd1};
    vecs[3]  = '{1'b1, 4'h9, 4'h7, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 8'hDB, 3'd1, 8'd1, 3'd1};
    vecs[4]  = '{1'b1, 4'h5, 4'hB, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 8'h97, 3'd2, 8'd2, 3'd1};
    vecs[5]  = '{1'b1, 4'h9, 4'h7, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5B, 3'd3, 8'd3, 3'd1};
    vecs[6]  = '{1'b1, 4'hA, 4'hB, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 8'h97, 3'd4, 8'd4, 3'd1};
    vecs[7]  = '{1'b1, 4'hA, 4'h7, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 8'hAB, 3'd5, 8'd5, 3'd1};
    vecs[8]  = '{1'b1, 4'h5, 4'hB, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA7, 3'd6, 8'd6, 3'd1};
    vecs[9]  = '{1'b0, 4'h0, 4'h0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5B, 3'd7, 8'd7, 3'd0};
    vecs[10] = '{1'b0, 4'h0, 4'h0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5B, 3'd7, 8'd7, 3'd0};

    rst = 1; in_valid = 0; in_a = 0; in_b = 0; in_s = 0; out_ready = 0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      cycle(vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].ordy, vecs[i].r);
      chk($sformatf("vec%0d in_ready", i), pre_in_ready, vecs[i].rdy);
      chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].ov);
      chk($sformatf("vec%0d out_y", i), out_y, vecs[i].y);
      chk($sformatf("vec%0d out_s", i), out_s, vecs[i].os);
      chk($sformatf("vec%0d out_seq", i), out_seq, vecs[i].seq);
      chk($sformatf("vec%0d count", i), count, vecs[i].cnt);
    end

    // Fill with out_ready low: 5 accepted, FIFO full.
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 4'(i + 1), 4'(i + 8), 3'(i), 1'b0, 1'b0);
    chk("full count", count, 3'd4);
    chk("full in_ready", in_ready, 1'b0);
    chk("full out_valid", out_valid, 1'b1);
    // One-cycle out_ready pulse while in_valid: pop but no push.
    cycle(1'b1, 4'hE, 4'h1, 3'd2, 1'b1, 1'b0);
    chk("pulse no-push", pre_in_ready, 1'b0);
    chk("pulse count", count, 3'd3);
    chk("pulse in_ready", in_ready, 1'b1);
    cycle(1'b1, 4'hE, 4'h1, 3'd2, 1'b0, 1'b0);
    chk("late push count", count, 3'd4);
    for (int i = 0; i < 7; i++)
      cycle(1'b0, 4'h0, 4'h0, 3'd0, 1'b1, 1'b0);
    chk("drained count", count, 3'd0);
    chk("drained out_valid", out_valid, 1'b0);

    // Reset mid-operation with count=3 and a result pending.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 4'(i), 4'(i + 4), 3'(i), 1'b0, 1'b0);
    chk("pre-rst count", count, 3'd3);
    chk("pre-rst out_valid", out_valid, 1'b1);
    cycle(1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b1);
    chk("rst count", count, 3'd0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_y", out_y, 8'h00);
    chk("rst out_seq", out_seq, 8'h00);
    cycle(1'b1, 4'h2, 4'h5, 3'd6, 1'b1, 1'b0);
    chk("post-rst in_ready", pre_in_ready, 1'b1);
    cycle(1'b0, 4'h0, 4'h0, 3'd0, 1'b1, 1'b0);
    chk("post-rst out_valid", out_valid, 1'b1);
    chk("post-rst out_y", out_y, 8'h25);
    chk("post-rst out_seq", out_seq, 8'd0);

    // 257-request stream: sequence wraps 255 -> 0.
    cycle(1'b0, 4'h0, 4'h0, 3'd0, 1'b1, 1'b1);
    saw255 = 0;
    for (int i = 0; i < 257; i++) begin
      cycle(1'b1, 4'($urandom), 4'($urandom), 3'($urandom), 1'b1, 1'b0);
      if (out_valid && out_seq == 8'd255) saw255 = 1;
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'h0, 4'h0, 3'd0, 1'b1, 1'b0);
      if (out_valid && out_seq == 8'd255) saw255 = 1;
    end
    chk("stream saw seq 255", 32'(saw255), 32'd1);
    chk("stream last seq", out_seq, 8'd0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 99) < 70), 4'($urandom), 4'($urandom), 3'($urandom),
            1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
